pipe_reg: RTL and testbench
===========================

Name: pipe_reg

Overview:
Parametrised pipeline register chain: the generalised successor to the single-stage resettable flop. It is the stage boundary for the pipelined LEGv8 datapath (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries N-bit data through STAGES flops with a per-stage valid bit. It supports stall (hold), flush (bubble insertion) and keeps a registered occupancy count.

Parameters:
N, 64, data width in bits (N >= 1)
STAGES, 1, number of register stages / latency in enabled cycles (STAGES >= 1)
RST_VAL, '0, N-bit value loaded into data on reset, flush and bubble

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
en  input  1  advance chain this cycle (0 = stall/hold)
flush  input  1  synchronous clear of all stages; priority over en
d_valid  input  1  input entry valid
d  input  N  input data
q_valid  output  1  valid bit of last stage
q  output  N  data of last stage
occupancy  output  $clog2(STAGES+1)  registered count of valid stages

Behaviour:
- Reset (reset==0, async, independent of clk): every stage valid=0 and data=RST_VAL; q=RST_VAL, q_valid=0, occupancy=0. Takes effect without a clock edge. Release is sampled at the next rising edge.
- Rising edge with reset==1. Priority: flush > en > hold.
  - flush=1: all valid=0, all data=RST_VAL, occupancy=0. This holds regardless of en, d_valid and d.
  - en=1, flush=0: stage0 <= {d_valid, d_valid ? d : RST_VAL}; stage i <= stage i-1 for i=1..STAGES-1. Data of a bubble is forced to RST_VAL.
  - en=0, flush=0: all stages, q, q_valid and occupancy hold. d and d_valid are ignored.
- Outputs are taken directly from the last stage flops. No combinational path from d to q.
- Latency: an entry presented with en=1 appears on q after exactly STAGES enabled edges. Stalled cycles do not count.
- occupancy is a registered up/down counter. On an en edge: occ <= occ + d_valid - (valid of last stage before the edge). Otherwise occ holds, or is cleared by flush.
- Invariant: occupancy == popcount(stage valid bits) at every edge. It never exceeds STAGES and never underflows. Full chain with en=1 and d_valid=1: occupancy stays STAGES.
- Simultaneous flush and en=1 with d_valid=1: the incoming entry is discarded; occupancy becomes 0.
- Reset asserted mid-operation discards all in-flight entries. No partial state survives.
- STAGES=1, flush=0, en=1, d_valid=1: functionally identical to the plain resettable flop, except that reset polarity is active-low.

Decomposition:
- Shared package pipe_pkg: no typedefs required beyond occupancy width helper localparam OCC_W = $clog2(STAGES+1). Computed locally in the module; package holds common RST_VAL constants for pipeline-register users (e.g. NOP encoding).
- One sub-module: pipe_stage, a single {valid, data} flop with en, clear and async active-low reset. It is instantiated STAGES times in a generate loop.
- The occupancy counter lives in pipe_reg.
- The module includes an elaboration-time check that STAGES >= 1 and N >= 1.

Test Plan:
1. N=64, STAGES=3, RST_VAL=0. Assert reset=0 at 27ns (mid-cycle) after loading entries. The required response is q=0, q_valid=0 and occupancy=0 before the next edge.
2. en=1, d_valid=1, d=64'hFFFF_FFFF_FFFF_FFFF then decrementing by 1 each cycle for 8 cycles. q shows FFFF..FFFF on the 3rd edge, then FFFF..FFFE and so on. q_valid=1 from the 3rd edge onward. occupancy reads 1, 2, 3, 3, 3.
3. Chain full, then en=0 for 2 cycles with d=64'h1234 and d_valid=1. q, q_valid and occupancy=3 stay unchanged. 64'h1234 never appears on q.
4. Chain full, then flush=1 with en=1 and d=64'hAAAA. On the next edge q=0, q_valid=0 and occupancy=0. Repeat with en=0: same result.
5. Stream 5, bubble (d_valid=0, d=64'hDEAD), 7. Three enabled edges after the bubble enters, q_valid=0 and q=0 (not DEAD). The 5 and 7 entries arrive unaffected. occupancy dips to 2 while the bubble is in the chain.
6. N=8, STAGES=1, RST_VAL=8'h5A. After reset, q=8'h5A. With en=1, d=8'h3C, d_valid=1: q=8'h3C one edge later, occupancy=1. Then d_valid=0: q=8'h5A, q_valid=0, occupancy=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for pipeline-register users
package pipe_pkg;
  localparam logic [31:0] LEGV8_NOP = 32'hD503201F;
  localparam logic [63:0] ZERO64 = 64'h0;
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one {valid, data} flop with enable, sync clear and async active-low reset
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int N = 64,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         valid_i,
  input  logic [N-1:0] data_i,
  output logic         valid_o,
  output logic [N-1:0] data_o
);
  logic valid_q, valid_d;
  logic [N-1:0] data_q, data_d;
  // bubbles always carry RST_VAL so invalid stages never expose stale data
  always_comb begin
    valid_d = clr_i ? 1'b0 : en_i ? valid_i : valid_q;
    data_d  = clr_i ? RST_VAL : en_i ? (valid_i ? data_i : RST_VAL) : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: STAGES-deep pipeline register chain with stall, flush and occupancy count
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int N = 64,
  parameter int STAGES = 1,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          d_valid,
  input  logic [N-1:0]                  d,
  output logic                          q_valid,
  output logic [N-1:0]                  q,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);
  localparam int OCC_W = $clog2(STAGES + 1);
  if (STAGES < 1 || N < 1) begin : g_bad_params
    $error("pipe_reg: STAGES and N must both be >= 1");
  end
  logic         vld [STAGES+1];
  logic [N-1:0] dat [STAGES+1];
  logic [OCC_W-1:0] occ_q, occ_d;
  assign vld[0] = d_valid;
  assign dat[0] = d;
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_stage #(.N(N), .RST_VAL(RST_VAL)) u_stage (
      .clk     (clk),
      .rst_n   (reset),
      .en_i    (en),
      .clr_i   (flush),
      .valid_i (vld[g]),
      .data_i  (dat[g]),
      .valid_o (vld[g+1]),
      .data_o  (dat[g+1])
    );
  end
  // one entry in, the last-stage entry out: tracks popcount of stage valids
  always_comb begin
    occ_d = flush ? '0 : en ? occ_q + OCC_W'(d_valid) - OCC_W'(vld[STAGES]) : occ_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_q <= '0;
    else        occ_q <= occ_d;
  end
  assign q_valid   = vld[STAGES];
  assign q         = dat[STAGES];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: random and directed checks of pipe_reg against a history-queue model
module tb_pipe_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        en_a, fl_a, dv_a, qv_a;
  logic [63:0] d_a, q_a;
  logic [1:0]  occ_a;
  logic        en_b, fl_b, dv_b, qv_b;
  logic [7:0]  d_b, q_b;
  logic [0:0]  occ_b;

  pipe_reg #(.N(64), .STAGES(3), .RST_VAL(64'h0)) dut_a (
    .clk(clk), .reset(rst_n), .en(en_a), .flush(fl_a), .d_valid(dv_a), .d(d_a),
    .q_valid(qv_a), .q(q_a), .occupancy(occ_a)
  );
  pipe_reg #(.N(8), .STAGES(1), .RST_VAL(8'h5A)) dut_b (
    .clk(clk), .reset(rst_n), .en(en_b), .flush(fl_b), .d_valid(dv_b), .d(d_b),
    .q_valid(qv_b), .q(q_b), .occupancy(occ_b)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // model: the output is whatever was accepted STAGES enabled edges ago since the last clear
  logic [64:0] ha[$];
  logic [8:0]  hb[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ha.delete();
      hb.delete();
    end else begin
      if (fl_a) ha.delete();
      else if (en_a) begin
        ha.push_back({dv_a, dv_a ? d_a : 64'h0});
        if (ha.size() > 3) void'(ha.pop_front());
      end
      if (fl_b) hb.delete();
      else if (en_b) begin
        hb.push_back({dv_b, dv_b ? d_b : 8'h5A});
        if (hb.size() > 1) void'(hb.pop_front());
      end
    end
  end

  always @(negedge clk) begin : compare
    int na, nb;
    na = 0;
    nb = 0;
    foreach (ha[i]) na += int'(ha[i][64]);
    foreach (hb[i]) nb += int'(hb[i][8]);
    chk("model_q_a", q_a, ha.size() == 3 ? ha[0][63:0] : 64'h0);
    chk("model_qv_a", {63'h0, qv_a}, ha.size() == 3 ? {63'h0, ha[0][64]} : 64'h0);
    chk("model_occ_a", {62'h0, occ_a}, 64'(na));
    chk("model_q_b", {56'h0, q_b}, hb.size() == 1 ? {56'h0, hb[0][7:0]} : 64'h5A);
    chk("model_qv_b", {63'h0, qv_b}, hb.size() == 1 ? {63'h0, hb[0][8]} : 64'h0);
    chk("model_occ_b", {63'h0, occ_b}, 64'(nb));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] qs;
    logic        qvs;
    {en_a, fl_a, dv_a, d_a} = '0;
    {en_b, fl_b, dv_b, d_b} = '0;
    #1 rst_n = 1'b0;
    tick();
    chk("rst_q_b", {56'h0, q_b}, 64'h5A);
    chk("rst_q_a", q_a, 64'h0);
    chk("rst_occ_a", {62'h0, occ_a}, 64'h0);
    rst_n = 1'b1;
    en_a = 1'b1; dv_a = 1'b1; d_a = 64'h11;
    tick();
    d_a = 64'h22;
    @(posedge clk);
    #1 chk("preload_occ", {62'h0, occ_a}, 64'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_q", q_a, 64'h0);
    chk("async_rst_qv", {63'h0, qv_a}, 64'h0);
    chk("async_rst_occ", {62'h0, occ_a}, 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_a = 64'hFFFF_FFFF_FFFF_FFFF - 64'(i);
      tick();
      chk("stream_occ", {62'h0, occ_a}, i < 2 ? 64'(i + 1) : 64'h3);
      if (i >= 2) begin
        chk("stream_q", q_a, 64'hFFFF_FFFF_FFFF_FFFF - 64'(i - 2));
        chk("stream_qv", {63'h0, qv_a}, 64'h1);
      end
    end
    qs = q_a;
    qvs = qv_a;
    en_a = 1'b0; d_a = 64'h1234;
    repeat (2) begin
      tick();
      chk("stall_q", q_a, qs);
      chk("stall_qv", {63'h0, qv_a}, {63'h0, qvs});
      chk("stall_occ", {62'h0, occ_a}, 64'h3);
    end
    en_a = 1'b1; fl_a = 1'b1; d_a = 64'hAAAA;
    tick();
    chk("flush_en_q", q_a, 64'h0);
    chk("flush_en_qv", {63'h0, qv_a}, 64'h0);
    chk("flush_en_occ", {62'h0, occ_a}, 64'h0);
    fl_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      d_a = 64'(i);
      tick();
    end
    chk("refill_occ", {62'h0, occ_a}, 64'h3);
    en_a = 1'b0; fl_a = 1'b1;
    tick();
    chk("flush_stall_q", q_a, 64'h0);
    chk("flush_stall_qv", {63'h0, qv_a}, 64'h0);
    chk("flush_stall_occ", {62'h0, occ_a}, 64'h0);
    fl_a = 1'b0; en_a = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      d_a = 64'(i);
      tick();
    end
    d_a = 64'h5;
    tick();
    dv_a = 1'b0; d_a = 64'hDEAD;
    tick();
    chk("bubble_occ1", {62'h0, occ_a}, 64'h2);
    dv_a = 1'b1; d_a = 64'h7;
    tick();
    chk("bubble_q5", q_a, 64'h5);
    chk("bubble_occ2", {62'h0, occ_a}, 64'h2);
    d_a = 64'h8;
    tick();
    chk("bubble_q", q_a, 64'h0);
    chk("bubble_qv", {63'h0, qv_a}, 64'h0);
    chk("bubble_occ3", {62'h0, occ_a}, 64'h2);
    d_a = 64'h9;
    tick();
    chk("bubble_q7", q_a, 64'h7);
    chk("bubble_occ4", {62'h0, occ_a}, 64'h3);
    en_a = 1'b0;
    en_b = 1'b1; dv_b = 1'b1; d_b = 8'h3C;
    tick();
    chk("s1_q", {56'h0, q_b}, 64'h3C);
    chk("s1_qv", {63'h0, qv_b}, 64'h1);
    chk("s1_occ", {63'h0, occ_b}, 64'h1);
    dv_b = 1'b0;
    tick();
    chk("s1_bubble_q", {56'h0, q_b}, 64'h5A);
    chk("s1_bubble_qv", {63'h0, qv_b}, 64'h0);
    chk("s1_bubble_occ", {63'h0, occ_b}, 64'h0);
    for (int i = 0; i < 600; i++) begin
      en_a = $urandom_range(0, 3) != 0;
      fl_a = $urandom_range(0, 15) == 0;
      dv_a = $urandom_range(0, 3) != 0;
      d_a  = {$urandom, $urandom};
      en_b = $urandom_range(0, 3) != 0;
      fl_b = $urandom_range(0, 15) == 0;
      dv_b = $urandom_range(0, 1) != 0;
      d_b  = 8'($urandom);
      if ($urandom_range(0, 80) == 0) begin
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
